// File: rtl/start_seq_gen.sv
// start_seq_gen: drives Start high to arm a far-end start detector, waits for READY,
// holds the link up and retries after a low gap on timeout or link loss.
module start_seq_gen #(
    parameter int RUN_LEN   = 4,
    parameter int HOLD_MAX  = 16,
    parameter int GAP       = 2,
    parameter int MAX_RETRY = 3,
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          req,
    input  logic          detector_out,
    output logic          Start,
    output logic          busy,
    output logic          done,
    output logic          lost,
    output logic          fail,
    output logic [RW-1:0] retry_cnt
);
    localparam int CMAX = (RUN_LEN > HOLD_MAX) ? ((RUN_LEN > GAP) ? RUN_LEN : GAP)
                                               : ((HOLD_MAX > GAP) ? HOLD_MAX : GAP);
    localparam int CW = $clog2(CMAX + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DRIVE  = 3'd1,
        S_WAIT   = 3'd2,
        S_LINKED = 3'd3,
        S_GAP    = 3'd4,
        S_FAILED = 3'd5
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [RW-1:0] retry_q, retry_d;
    logic          start_q, start_d;
    logic          done_q, done_d;
    logic          lost_q, lost_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        retry_d = retry_q;
        done_d  = 1'b0;
        lost_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                retry_d = '0;
                if (req) state_d = S_DRIVE;
            end
            S_DRIVE: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(RUN_LEN - 1)) state_d = S_WAIT;
            end
            S_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                if (detector_out) begin
                    state_d = S_LINKED;
                    done_d  = 1'b1;
                end else if (cnt_q == CW'(HOLD_MAX - 1)) begin
                    if (retry_q == RW'(MAX_RETRY)) state_d = S_FAILED;
                    else begin
                        state_d = S_GAP;
                        retry_d = retry_q + 1'b1;
                    end
                end
            end
            S_LINKED: begin
                if (!detector_out) begin
                    state_d = S_GAP;
                    lost_d  = 1'b1;
                    retry_d = '0;
                end
            end
            S_GAP: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(GAP - 1)) state_d = S_DRIVE;
            end
            S_FAILED: begin
                if (!req) begin
                    state_d = S_IDLE;
                    retry_d = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                retry_d = '0;
            end
        endcase
        // Dropping req aborts from anywhere except FAILED, which has its own release
        if (!req && state_q != S_FAILED) begin
            state_d = S_IDLE;
            retry_d = '0;
            done_d  = 1'b0;
            lost_d  = 1'b0;
        end
        if (state_d != state_q) cnt_d = '0;
        start_d = (state_d == S_DRIVE) || (state_d == S_WAIT) || (state_d == S_LINKED);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            retry_q <= '0;
            start_q <= 1'b0;
            done_q  <= 1'b0;
            lost_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            retry_q <= retry_d;
            start_q <= start_d;
            done_q  <= done_d;
            lost_q  <= lost_d;
        end
    end

    assign Start     = start_q;
    assign busy      = state_q != S_IDLE;
    assign done      = done_q;
    assign lost      = lost_q;
    assign fail      = state_q == S_FAILED;
    assign retry_cnt = retry_q;
endmodule

// File: tb/tb_start_seq_gen.sv
// tb_start_seq_gen: directed checks of start_seq_gen against a behavioural
// 4-cycle Moore start detector, with an override to force detector_out.
module tb_start_seq_gen;
    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       req = 1'b0;
    logic       detector_out;
    logic       Start, busy, done, lost, fail;
    logic [1:0] retry_cnt;
    logic       force_en = 1'b0;
    logic       force_val = 1'b0;
    logic [2:0] dcnt;
    logic       done_seen;
    int         checks = 0;
    int         errors = 0;

    start_seq_gen dut (
        .clock(clock), .reset_n(reset_n), .req(req), .detector_out(detector_out),
        .Start(Start), .busy(busy), .done(done), .lost(lost), .fail(fail),
        .retry_cnt(retry_cnt)
    );

    always #5 clock = ~clock;

    // Far-end detector: READY once Start has been sampled high four times in a row
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) dcnt <= 3'd0;
        else if (!Start) dcnt <= 3'd0;
        else if (dcnt < 3'd4) dcnt <= dcnt + 3'd1;
    end
    assign detector_out = force_en ? force_val : (dcnt == 3'd4);

    always @(posedge clock) if (done) done_seen <= 1'b1;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic restart();
        req = 1'b0;
        force_en = 1'b0;
        reset_n = 1'b0;
        step(2);
        reset_n = 1'b1;
        step(1);
    endtask

    initial begin
        restart();
        check("rst_start", int'(Start), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_flags", int'({done, lost, fail}), 0);
        check("rst_retry", int'(retry_cnt), 0);

        // basic bring-up: Start after E0, done after E5, release at E9
        req = 1'b1;
        step(1);
        check("t2_start_e0", int'(Start), 1);
        check("t2_busy_e0", int'(busy), 1);
        step(4);
        check("t2_done_e4", int'(done), 0);
        check("t2_ready_e4", int'(detector_out), 1);
        step(1);
        check("t2_done_e5", int'(done), 1);
        check("t2_start_e5", int'(Start), 1);
        step(1);
        check("t2_done_e6", int'(done), 0);
        step(2);
        req = 1'b0;
        step(1);
        check("t2_start_e9", int'(Start), 0);
        check("t2_busy_e9", int'(busy), 0);

        // async reset while linked, then restart with req still high
        restart();
        req = 1'b1;
        step(7);
        check("t1_pre_start", int'(Start), 1);
        #2 reset_n = 1'b0;
        #1;
        check("t1_start", int'(Start), 0);
        check("t1_busy", int'(busy), 0);
        check("t1_flags", int'({done, lost, fail}), 0);
        check("t1_retry", int'(retry_cnt), 0);
        reset_n = 1'b1;
        step(1);
        check("t1_restart", int'(Start), 1);
        step(5);
        check("t1_done", int'(done), 1);

        // detector dead: four 22-cycle attempts then FAILED
        restart();
        force_en = 1'b1;
        force_val = 1'b0;
        req = 1'b1;
        step(1);
        step(19);
        check("t3_start_e19", int'(Start), 1);
        step(1);
        check("t3_start_e20", int'(Start), 0);
        check("t3_retry_e20", int'(retry_cnt), 1);
        step(1);
        check("t3_start_e21", int'(Start), 0);
        step(1);
        check("t3_start_e22", int'(Start), 1);
        step(63);
        check("t3_start_e85", int'(Start), 1);
        check("t3_fail_e85", int'(fail), 0);
        check("t3_retry_e85", int'(retry_cnt), 3);
        step(1);
        check("t3_fail_e86", int'(fail), 1);
        check("t3_start_e86", int'(Start), 0);
        check("t3_retry_e86", int'(retry_cnt), 3);
        step(4);
        check("t3_fail_hold", int'(fail), 1);
        req = 1'b0;
        step(1);
        check("t3_fail_rel", int'(fail), 0);
        check("t3_busy_rel", int'(busy), 0);
        check("t3_retry_rel", int'(retry_cnt), 0);

        // link loss for one cycle: lost pulse, 2-cycle gap, re-link
        restart();
        req = 1'b1;
        step(6);
        check("t4_done_e5", int'(done), 1);
        step(2);
        force_en = 1'b1;
        force_val = 1'b0;
        step(1);
        force_en = 1'b0;
        check("t4_lost_e8", int'(lost), 1);
        check("t4_done_e8", int'(done), 0);
        check("t4_start_e8", int'(Start), 0);
        step(1);
        check("t4_lost_e9", int'(lost), 0);
        check("t4_start_e9", int'(Start), 0);
        step(1);
        check("t4_start_e10", int'(Start), 1);
        step(4);
        check("t4_done_e14", int'(done), 0);
        step(1);
        check("t4_done_e15", int'(done), 1);
        check("t4_retry", int'(retry_cnt), 0);

        // abort during DRIVE
        restart();
        done_seen = 1'b0;
        req = 1'b1;
        step(2);
        req = 1'b0;
        step(1);
        check("t5_start", int'(Start), 0);
        check("t5_busy", int'(busy), 0);
        step(6);
        check("t5_no_done", int'(done_seen), 0);
        check("t5_det_init", int'(detector_out), 0);

        // READY arrives exactly on the timeout cycle
        restart();
        force_en = 1'b1;
        force_val = 1'b0;
        req = 1'b1;
        step(20);
        check("t6_start_e19", int'(Start), 1);
        force_val = 1'b1;
        step(1);
        check("t6_done", int'(done), 1);
        check("t6_start", int'(Start), 1);
        check("t6_retry", int'(retry_cnt), 0);
        step(1);
        check("t6_linked", int'(Start), 1);
        check("t6_lost", int'(lost), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
